cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multicycle control sequencer for the 16-bit CPU. Steps each instruction through fetch, decode, execute and optional memory phases. Drives the load/write strobes for the instruction register, PC, register file and data memory, and owns the architectural N/Z flag register. Sits beside the combinational opcode decoder: it consumes the latched opcode and the ALU flags, and produces the per-cycle enables the decoder's static selects do not provide.

## Interface
- No parameters. Datapath width is fixed at 16 bits; opcode width at 5 bits.
- `clk` in 1: single clock. All state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 5: opcode field of the latched instruction register. Valid from DECODE onward.
- `alu_n`, `alu_z` in 1 each: combinational N/Z of the current ALU result.
- `mem_ready` in 1: memory acknowledge. Sampled only while `mem_req`=1.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: access is a write.
- `mem_sel` out 1: address source select. 0=PC (fetch), 1=data address (ld/st).
- `ir_load` out 1: instruction register load strobe.
- `pc_we` out 1: PC write strobe.
- `pc_src` out 2: PC source. 00=branch target, 01=register, 10=pc+2.
- `reg_we` out 1: register-file write strobe.
- `flag_n`, `flag_z` out 1 each: registered N/Z flags.
- `illegal` out 1: one-cycle pulse when an undefined opcode is decoded.
- `state` out 2: current state, for debug. FETCH=0, DECODE=1, EXEC=2, MEM=3.

## Operation
- **Reset:**
  - On any edge with `reset`=1: state←FETCH, `flag_n`=`flag_z`=0.
  - While `reset`=1, every output is forced to 0.
  - A reset mid-handshake abandons the access. `mem_req` drops the next cycle and no strobe fires.
- **FETCH:**
  - Outputs: `mem_req`=1, `mem_we`=0, `mem_sel`=0.
  - On the cycle `mem_ready`=1: `ir_load`=1, `pc_we`=1, `pc_src`=10, then go to DECODE.
  - Otherwise stay in FETCH with `mem_req` held.
- **DECODE:** no strobes; always go to EXEC. If the opcode is not in the list below, pulse `illegal`=1 in this cycle.
- **EXEC:** one cycle. Actions by opcode class:
  - **mv, add, sub, mvi, addi, subi, mvhi:** `reg_we`=1.
  - **Flag updates:** add, sub, cmp, addi, subi and cmpi load `flag_n`←`alu_n` and `flag_z`←`alu_z` at the end of EXEC. cmp and cmpi do not assert `reg_we`.
  - **jr:** `pc_we`=1, `pc_src`=01.
  - **jzr:** same as jr, gated by `flag_z`.
  - **jnr:** same as jr, gated by `flag_n`.
  - **j:** `pc_we`=1, `pc_src`=00.
  - **jz:** same as j, gated by `flag_z`.
  - **jn:** same as j, gated by `flag_n`.
  - **callr / call:** `reg_we`=1 (R7←incremented PC) and `pc_we`=1 in the same cycle, with `pc_src`=01 (callr) or 00 (call).
  - **Branch conditions:** use the flag values registered before this EXEC.
  - **Next state:** ld and st go to MEM; all others go to FETCH.
  - **Illegal opcodes:** no strobes (nop), then FETCH.
- **MEM:**
  - Outputs: `mem_req`=1, `mem_sel`=1, `mem_we`=1 for st and 0 for ld.
  - On `mem_ready`=1: ld asserts `reg_we`=1. Then go to FETCH.
  - Otherwise hold in MEM.
- **Opcode map:**
  - mv 00000, add 00001, sub 00010, cmp 00011, ld 00100, st 00101.
  - mvi 10000, addi 10001, subi 10010, cmpi 10011, mvhi 10110.
  - jr 01000, jzr 01001, jnr 01010, callr 01100.
  - j 11000, jz 11001, jn 11010, call 11100.
- **Mutual exclusion:** at most one of `ir_load` or an EXEC/MEM `reg_we` fires per cycle. `pc_we` fires at most once per state visit.
- **Spurious acknowledge:** `mem_ready` asserted with `mem_req`=0 is ignored.

## Timing
- `state`, `mem_req`, `mem_we`, `mem_sel` and `pc_src` are Moore outputs, decoded from `state` and `opcode` only.
- `ir_load`, the FETCH `pc_we` and the MEM `reg_we` are Mealy outputs: combinational on `mem_ready` in the same cycle.
- **Latency with zero-wait memory** (`mem_ready` high on the first request cycle):
  - ALU, move and branch instructions: 3 cycles (F, D, E).
  - ld and st: 4 cycles (F, D, E, M).
  - Each memory wait cycle adds 1.
- The flag update is visible on `flag_n` and `flag_z` the cycle after EXEC. A conditional branch immediately following a flag-setting instruction therefore sees the new flags.
- First `mem_req` after reset: the first cycle with `reset`=0.

## Test plan
- **Reset behaviour:** hold `reset` 2 cycles with `mem_ready`=1 → all outputs 0. The first cycle after release shows `state`=0, `mem_req`=1, `mem_sel`=0.
- **Back-to-back add then cmp**, zero-wait memory:
  - add: `alu_n`=0, `alu_z`=1 → `reg_we` in cycle 3, then `flag_z`=1, `flag_n`=0.
  - cmp: `alu_n`=1, `alu_z`=0 → no `reg_we`; `flag_n`=1, `flag_z`=0 afterwards.
- **Fetch wait states:** `mem_ready` low for 3 cycles → `mem_req` held 4 cycles, with `ir_load` and `pc_write` (`pc_src`=10) only in the 4th.
- **Conditional jumps, with `flag_z`=0 then 1:**
  - jz with `flag_z`=0: no `pc_we` in EXEC.
  - jz with `flag_z`=1: `pc_we`=1, `pc_src`=00.
  - call: `reg_we`=1 and `pc_we`=1 in the same EXEC cycle.
- **Loads and stores, 1 memory wait each:**
  - ld: MEM lasts 2 cycles, `mem_we`=0, `reg_we` on the 2nd.
  - st: `mem_we`=1, no `reg_we`.
  - Both return to FETCH.
- **Illegal opcode and mid-access reset:**
  - Opcode 11111 → `illegal` pulse in DECODE, no strobes in EXEC, then FETCH.
  - `reset` asserted during MEM wait → `mem_req`=0 next cycle, flags cleared, restart at FETCH.

Source files
------------

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multicycle FETCH/DECODE/EXEC/MEM control sequencer for the
// 16-bit CPU. Produces the per-cycle load/write strobes for IR, PC, register
// file and data memory, and holds the architectural N/Z flag register.
module cpu_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] opcode,
    input  logic       alu_n,
    input  logic       alu_z,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_sel,
    output logic       ir_load,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic       flag_n,
    output logic       flag_z,
    output logic       illegal,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_MEM    = 2'd3
    } state_t;

    localparam logic [1:0] PC_SRC_TARGET = 2'b00;
    localparam logic [1:0] PC_SRC_REG    = 2'b01;
    localparam logic [1:0] PC_SRC_INCR   = 2'b10;

    state_t state_reg;
    state_t state_next;
    logic   flag_n_reg;
    logic   flag_z_reg;

    // Opcode classification
    logic op_legal;
    logic op_reg_write;
    logic op_flags;
    logic op_jump;
    logic op_jump_reg;
    logic op_cond_z;
    logic op_cond_n;
    logic op_mem;
    logic op_store;
    logic jump_taken;

    // Classify the latched opcode into the action groups the FSM needs
    always_comb begin
        op_legal     = 1'b1;
        op_reg_write = 1'b0;
        op_flags     = 1'b0;
        op_jump      = 1'b0;
        op_jump_reg  = 1'b0;
        op_cond_z    = 1'b0;
        op_cond_n    = 1'b0;
        op_mem       = 1'b0;
        op_store     = 1'b0;
        case (opcode)
            5'b00000: op_reg_write = 1'b1;                               // mv
            5'b00001: begin op_reg_write = 1'b1; op_flags = 1'b1; end    // add
            5'b00010: begin op_reg_write = 1'b1; op_flags = 1'b1; end    // sub
            5'b00011: op_flags = 1'b1;                                   // cmp
            5'b00100: op_mem = 1'b1;                                     // ld
            5'b00101: begin op_mem = 1'b1; op_store = 1'b1; end          // st
            5'b10000: op_reg_write = 1'b1;                               // mvi
            5'b10001: begin op_reg_write = 1'b1; op_flags = 1'b1; end    // addi
            5'b10010: begin op_reg_write = 1'b1; op_flags = 1'b1; end    // subi
            5'b10011: op_flags = 1'b1;                                   // cmpi
            5'b10110: op_reg_write = 1'b1;                               // mvhi
            5'b01000: begin op_jump = 1'b1; op_jump_reg = 1'b1; end      // jr
            5'b01001: begin op_jump = 1'b1; op_jump_reg = 1'b1; op_cond_z = 1'b1; end // jzr
            5'b01010: begin op_jump = 1'b1; op_jump_reg = 1'b1; op_cond_n = 1'b1; end // jnr
            5'b01100: begin op_jump = 1'b1; op_jump_reg = 1'b1; op_reg_write = 1'b1; end // callr
            5'b11000: op_jump = 1'b1;                                    // j
            5'b11001: begin op_jump = 1'b1; op_cond_z = 1'b1; end        // jz
            5'b11010: begin op_jump = 1'b1; op_cond_n = 1'b1; end        // jn
            5'b11100: begin op_jump = 1'b1; op_reg_write = 1'b1; end     // call
            default:  op_legal = 1'b0;
        endcase
    end

    // Branch conditions look at the flags registered before this EXEC
    assign jump_taken = op_jump
                      & (~op_cond_z | flag_z_reg)
                      & (~op_cond_n | flag_n_reg);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // N/Z flags: loaded from the ALU at the end of a flag-setting EXEC
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_n_reg <= 1'b0;
            flag_z_reg <= 1'b0;
        end else if (state_reg == S_EXEC && op_flags) begin
            flag_n_reg <= alu_n;
            flag_z_reg <= alu_z;
        end
    end

    // Next state and strobes; handshake strobes are Mealy on mem_ready
    always_comb begin
        state_next = state_reg;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_sel    = 1'b0;
        ir_load    = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_SRC_INCR;
        reg_we     = 1'b0;
        illegal    = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load    = 1'b1;
                    pc_we      = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                illegal    = ~op_legal;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                reg_we = op_reg_write;
                pc_we  = jump_taken;
                if (op_jump) begin
                    pc_src = op_jump_reg ? PC_SRC_REG : PC_SRC_TARGET;
                end
                state_next = op_mem ? S_MEM : S_FETCH;
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                mem_we  = op_store;
                if (mem_ready) begin
                    reg_we     = ~op_store;
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_FETCH;
        endcase
        // Reset silences every output, abandoning any access in flight
        if (reset) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            mem_sel = 1'b0;
            ir_load = 1'b0;
            pc_we   = 1'b0;
            pc_src  = 2'b00;
            reg_we  = 1'b0;
            illegal = 1'b0;
        end
    end

    assign flag_n = flag_n_reg & ~reset;
    assign flag_z = flag_z_reg & ~reset;
    assign state  = reset ? 2'b00 : state_reg;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: builds a per-cycle timeline of stimulus and expected
// outputs from an instruction-level model, drives it into cpu_sequencer and
// compares every cycle, plus literal spot checks on the directed prefix.
module tb_cpu_sequencer;

    logic       clk;
    logic       reset;
    logic [4:0] opcode;
    logic       alu_n;
    logic       alu_z;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       mem_sel;
    logic       ir_load;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic       flag_n;
    logic       flag_z;
    logic       illegal;
    logic [1:0] state;

    cpu_sequencer dut (
        .clk(clk), .reset(reset), .opcode(opcode), .alu_n(alu_n), .alu_z(alu_z),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
        .ir_load(ir_load), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
        .flag_n(flag_n), .flag_z(flag_z), .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [4:0] op;
        logic       an;
        logic       az;
        logic       rdy;
        logic       mem_req;
        logic       mem_we;
        logic       mem_sel;
        logic       ir_load;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       reg_we;
        logic       fn;
        logic       fz;
        logic       ill;
        logic [1:0] st;
        logic       tag;
    } cyc_t;

    cyc_t sched[$];
    int   lit_cyc[$];
    int   lit_sig[$];
    int   lit_val[$];
    bit   mf_n, mf_z;
    int   total = 0;
    int   bad = 0;
    int   cur = 0;
    int   ninstr = 0;
    bit   active = 0;

    logic [4:0] legal_ops [19] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h10,
        5'h11, 5'h12, 5'h13, 5'h16, 5'h08, 5'h09, 5'h0A, 5'h0C, 5'h18, 5'h19, 5'h1A, 5'h1C};

    // Instruction-set facts, as plain set membership
    function automatic bit is_legal(logic [4:0] op);
        return op inside {5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h10, 5'h11, 5'h12,
                          5'h13, 5'h16, 5'h08, 5'h09, 5'h0A, 5'h0C, 5'h18, 5'h19, 5'h1A, 5'h1C};
    endfunction
    function automatic bit writes_reg(logic [4:0] op);
        return op inside {5'h00, 5'h01, 5'h02, 5'h10, 5'h11, 5'h12, 5'h16, 5'h0C, 5'h1C};
    endfunction
    function automatic bit sets_flags(logic [4:0] op);
        return op inside {5'h01, 5'h02, 5'h03, 5'h11, 5'h12, 5'h13};
    endfunction
    function automatic bit is_jump(logic [4:0] op);
        return op inside {5'h08, 5'h09, 5'h0A, 5'h0C, 5'h18, 5'h19, 5'h1A, 5'h1C};
    endfunction
    function automatic bit reg_target(logic [4:0] op);
        return op inside {5'h08, 5'h09, 5'h0A, 5'h0C};
    endfunction

    function automatic cyc_t idle(logic [1:0] st);
        cyc_t c;
        c     = '0;
        c.op  = 5'($urandom);
        c.an  = 1'($urandom);
        c.az  = 1'($urandom);
        c.rdy = 1'($urandom);
        c.st  = st;
        c.fn  = mf_n;
        c.fz  = mf_z;
        return c;
    endfunction

    function automatic cyc_t reset_cycle(logic rdy);
        cyc_t c;
        c     = '0;
        c.rst = 1'b1;
        c.op  = 5'($urandom);
        c.rdy = rdy;
        c.tag = 1'b1;
        mf_n  = 1'b0;
        mf_z  = 1'b0;
        return c;
    endfunction

    // Append one instruction's cycles: fw fetch waits, mw memory waits,
    // an/az = 0/1 fixed or 2 random, rst_at = MEM cycle replaced by reset (-1 none)
    task automatic add_instr(input logic [4:0] op, input int fw, input int mw,
                             input int an, input int az, input int rst_at);
        cyc_t c;
        bit   taken, is_ld, is_st;
        for (int w = 0; w <= fw; w++) begin
            c         = idle(2'd0);
            c.mem_req = 1'b1;
            c.rdy     = (w == fw);
            if (w == fw) begin
                c.ir_load = 1'b1;
                c.pc_we   = 1'b1;
                c.pc_src  = 2'b10;
            end
            sched.push_back(c);
        end
        c     = idle(2'd1);
        c.op  = op;
        c.ill = !is_legal(op);
        sched.push_back(c);
        c        = idle(2'd2);
        c.op     = op;
        if (an != 2) c.an = 1'(an);
        if (az != 2) c.az = 1'(az);
        c.reg_we = writes_reg(op);
        taken    = is_jump(op) &&
                   !((op inside {5'h09, 5'h19}) && !mf_z) &&
                   !((op inside {5'h0A, 5'h1A}) && !mf_n);
        c.pc_we  = taken;
        c.pc_src = reg_target(op) ? 2'b01 : 2'b00;
        is_ld    = (op == 5'h04);
        is_st    = (op == 5'h05);
        c.tag    = !(is_ld || is_st);
        sched.push_back(c);
        if (sets_flags(op)) begin
            mf_n = c.an;
            mf_z = c.az;
        end
        if (is_ld || is_st) begin
            for (int w = 0; w <= mw; w++) begin
                if (w == rst_at) begin
                    sched.push_back(reset_cycle(1'($urandom)));
                    return;
                end
                c         = idle(2'd3);
                c.op      = op;
                c.mem_req = 1'b1;
                c.mem_sel = 1'b1;
                c.mem_we  = is_st;
                c.rdy     = (w == mw);
                c.reg_we  = is_ld && (w == mw);
                c.tag     = (w == mw);
                sched.push_back(c);
            end
        end
    endtask

    task automatic lit(input int cyc, input int sig, input int val);
        lit_cyc.push_back(cyc);
        lit_sig.push_back(sig);
        lit_val.push_back(val);
    endtask

    function automatic logic dut_sig(int s);
        case (s)
            0: return reg_we;
            1: return flag_n;
            2: return flag_z;
            3: return pc_we;
            4: return illegal;
            5: return mem_req;
            6: return ir_load;
            default: return mem_we;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL cycle %0d %s: got %0d want %0d", cur, nm, act, exp);
        end
    endtask

    // Single compare process: every cycle against the model timeline
    always @(negedge clk) begin
        if (active) begin
            cyc_t e;
            e = sched[cur];
            chk("state",   int'(state),   int'(e.st));
            chk("mem_req", int'(mem_req), int'(e.mem_req));
            chk("mem_we",  int'(mem_we),  int'(e.mem_we));
            chk("mem_sel", int'(mem_sel), int'(e.mem_sel));
            chk("ir_load", int'(ir_load), int'(e.ir_load));
            chk("pc_we",   int'(pc_we),   int'(e.pc_we));
            chk("reg_we",  int'(reg_we),  int'(e.reg_we));
            chk("flag_n",  int'(flag_n),  int'(e.fn));
            chk("flag_z",  int'(flag_z),  int'(e.fz));
            chk("illegal", int'(illegal), int'(e.ill));
            if (e.pc_we) chk("pc_src", int'(pc_src), int'(e.pc_src));
            foreach (lit_cyc[k]) begin
                if (lit_cyc[k] == cur) chk($sformatf("lit%0d", k), int'(dut_sig(lit_sig[k])), lit_val[k]);
            end
            if (e.tag) begin
                ninstr++;
                $display("txn %0d: op=%05b rst=%0d ends at cycle %0d", ninstr, e.op, e.rst, cur);
            end
        end
    end

    initial begin
        mf_n = 1'b0;
        mf_z = 1'b0;
        // Directed prefix: reset, add/cmp, fetch waits, jz both ways, call, ld/st, illegal, reset in MEM
        sched.push_back(reset_cycle(1'b1));
        sched.push_back(reset_cycle(1'b1));
        add_instr(5'h01, 0, 0, 0, 1, -1);   // add   F2 D3 E4
        add_instr(5'h03, 0, 0, 1, 0, -1);   // cmp   F5 D6 E7
        add_instr(5'h19, 3, 0, 2, 2, -1);   // jz    F8..11 D12 E13 (z=0)
        add_instr(5'h11, 0, 0, 0, 1, -1);   // addi  F14 D15 E16
        add_instr(5'h19, 0, 0, 2, 2, -1);   // jz    F17 D18 E19 (z=1)
        add_instr(5'h1C, 0, 0, 2, 2, -1);   // call  F20 D21 E22
        add_instr(5'h04, 0, 1, 2, 2, -1);   // ld    F23 D24 E25 M26 M27
        add_instr(5'h05, 0, 1, 2, 2, -1);   // st    F28 D29 E30 M31 M32
        add_instr(5'h1F, 0, 0, 2, 2, -1);   // ill   F33 D34 E35
        add_instr(5'h04, 0, 2, 2, 2, 1);    // ld    F36 D37 E38 M39, reset at 40
        // Hand-computed expectations pinning the model
        lit(0, 5, 0);  lit(1, 5, 0);  lit(2, 5, 1);
        lit(4, 0, 1);  lit(5, 2, 1);  lit(5, 1, 0);
        lit(7, 0, 0);  lit(8, 1, 1);  lit(8, 2, 0);
        lit(10, 6, 0); lit(11, 6, 1); lit(13, 3, 0);
        lit(19, 3, 1); lit(22, 0, 1); lit(22, 3, 1);
        lit(26, 0, 0); lit(27, 0, 1); lit(32, 7, 1); lit(32, 0, 0);
        lit(34, 4, 1); lit(35, 3, 0); lit(35, 0, 0);
        lit(39, 2, 1); lit(40, 5, 0); lit(41, 5, 1); lit(41, 2, 0);
        // Randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            logic [4:0] op;
            int fw, mw, ra;
            op = ($urandom_range(0, 7) == 0) ? 5'($urandom) : legal_ops[$urandom_range(0, 18)];
            fw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            mw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            ra = ((op == 5'h04 || op == 5'h05) && $urandom_range(0, 9) == 0) ? $urandom_range(0, mw) : -1;
            add_instr(op, fw, mw, 2, 2, ra);
        end

        for (int i = 0; i < sched.size(); i++) begin
            reset     = sched[i].rst;
            opcode    = sched[i].op;
            alu_n     = sched[i].an;
            alu_z     = sched[i].az;
            mem_ready = sched[i].rdy;
            cur       = i;
            active    = 1'b1;
            @(posedge clk);
            #1;
        end
        active = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
